// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-requester round-robin arbiter and sequencer for the shared ALU/divider.
// Optional EXEC watchdog is built when ALU_ARB_TIMEOUT_EN is defined.
module alu_req_arbiter #(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  logic [13:0]         req_op_i,
   input  logic [2*DATA_W-1:0] req_a_i,
   input  logic [2*DATA_W-1:0] req_b_i,
   input  logic [2*TAG_W-1:0]  req_tag_i,
   output logic                alu_en_o,
   output logic [6:0]          alu_operator_o,
   output logic [DATA_W-1:0]   alu_operand_a_o,
   output logic [DATA_W-1:0]   alu_operand_b_o,
   input  logic                alu_ready_i,
   input  logic [DATA_W-1:0]   alu_result_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic                rsp_id_o,
   output logic [TAG_W-1:0]    rsp_tag_o,
   output logic [DATA_W-1:0]   rsp_data_o,
   output logic                rsp_err_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;

   if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_timeout_range
      $error("alu_req_arbiter: TIMEOUT must be in 2..1023");
   end

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_last_grant;
   logic                w_grant_vld;
   logic                w_grant_id;
   logic                w_accept;
   logic                w_timeout;
   logic [6:0]          r_op;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [TAG_W-1:0]    r_tag;
   logic                r_id;
   logic [DATA_W-1:0]   r_data;

   // Round-robin: the requester that did not win last time has priority.
   always_comb begin
      w_grant_vld = |req_valid_i;
      w_grant_id  = ~r_last_grant;
      if (!req_valid_i[w_grant_id]) begin
         w_grant_id = r_last_grant;
      end
   end

   assign w_accept = (r_state == ST_IDLE) && w_grant_vld;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam logic [9:0] WDOG_LIMIT = 10'(TIMEOUT - 1);
   logic [9:0] r_wdog;
   logic       r_err;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wdog <= '0;
      end else if (w_accept) begin
         r_wdog <= '0;
      end else if (r_state == ST_EXEC && !alu_ready_i) begin
         r_wdog <= r_wdog + 10'd1;
      end
   end

   // alu_ready_i has priority over an expiring watchdog in the same cycle.
   assign w_timeout = (r_state == ST_EXEC) && !alu_ready_i && (r_wdog == WDOG_LIMIT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if (r_state == ST_EXEC && (alu_ready_i || w_timeout)) begin
         r_err <= w_timeout;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_last_grant <= w_grant_id;
         end
      end
   end

   // Request payload and result registers carry no reset; outputs are gated by state.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_id  <= w_grant_id;
         r_op  <= w_grant_id ? req_op_i[13:7] : req_op_i[6:0];
         r_a   <= w_grant_id ? req_a_i[2*DATA_W-1:DATA_W] : req_a_i[DATA_W-1:0];
         r_b   <= w_grant_id ? req_b_i[2*DATA_W-1:DATA_W] : req_b_i[DATA_W-1:0];
         r_tag <= w_grant_id ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
      end
      if (r_state == ST_EXEC && (alu_ready_i || w_timeout)) begin
         r_data <= alu_ready_i ? alu_result_i : '0;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      req_ready_o     = 2'b00;
      alu_en_o        = 1'b0;
      alu_operator_o  = '0;
      alu_operand_a_o = '0;
      alu_operand_b_o = '0;
      rsp_valid_o     = 1'b0;
      rsp_id_o        = 1'b0;
      rsp_tag_o       = '0;
      rsp_data_o      = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_vld) begin
               w_state_nxt = ST_EXEC;
               if (!rst_i) begin
                  req_ready_o = w_grant_id ? 2'b10 : 2'b01;
               end
            end
         end
         ST_EXEC: begin
            alu_en_o        = 1'b1;
            alu_operator_o  = r_op;
            alu_operand_a_o = r_a;
            alu_operand_b_o = r_b;
            if (alu_ready_i || w_timeout) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid_o = 1'b1;
            rsp_id_o    = r_id;
            rsp_tag_o   = r_tag;
            rsp_data_o  = r_data;
            if (rsp_ready_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef ALU_ARB_TIMEOUT_EN
   assign rsp_err_o = (r_state == ST_RESP) && r_err;
`else
   assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: transaction-level reference model with random
// and directed stimulus; the watchdog scenario follows ALU_ARB_TIMEOUT_EN.
module tb_alu_req_arbiter;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam int TO = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_ready;
   logic [13:0]     req_op = '0;
   logic [2*DW-1:0] req_a = '0;
   logic [2*DW-1:0] req_b = '0;
   logic [2*TW-1:0] req_tag = '0;
   logic            alu_en;
   logic [6:0]      alu_op;
   logic [DW-1:0]   alu_a;
   logic [DW-1:0]   alu_b;
   logic            alu_ready = 1'b0;
   logic [DW-1:0]   alu_result = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b1;
   logic            rsp_id;
   logic [TW-1:0]   rsp_tag;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;

   always #5 clk = ~clk;

   alu_req_arbiter #(.DATA_W(DW), .TAG_W(TW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_a_i(req_a), .req_b_i(req_b), .req_tag_i(req_tag),
      .alu_en_o(alu_en), .alu_operator_o(alu_op),
      .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
      .alu_ready_i(alu_ready), .alu_result_i(alu_result),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
      .rsp_tag_o(rsp_tag), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
   );

   typedef struct {
      int            id;
      logic [6:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] res;
      logic [TW-1:0] tag;
      int            lat;    // cycle of EXEC in which the ALU answers; 0 = never
      int            avail;  // run-relative cycle at which the request appears
   } op_t;

   op_t q0[$];
   op_t q1[$];
   op_t cur;
   int  g_id[$];
   int  g_cyc[$];
   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  acc = 0;
   int  m_last = 1;
   int  n_done = 0;
   bit  busy = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void add(input int id, input logic [6:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [TW-1:0] tag, input int lat,
                               input logic [DW-1:0] res, input int avail);
      op_t o;
      o.id = id; o.op = op; o.a = a; o.b = b; o.tag = tag; o.lat = lat; o.res = res; o.avail = avail;
      if (id == 0) q0.push_back(o);
      else q1.push_back(o);
   endfunction

   // Number of EXEC cycles the operation occupies.
   function automatic int eff_lat(input int lat);
`ifdef ALU_ARB_TIMEOUT_EN
      if (lat == 0 || lat > TO) return TO;
      return lat;
`else
      if (lat == 0) return 1 << 30;
      return lat;
`endif
   endfunction

   function automatic bit exp_err(input int lat);
`ifdef ALU_ARB_TIMEOUT_EN
      return (lat == 0 || lat > TO);
`else
      return 1'b0;
`endif
   endfunction

   task automatic apply_reset();
      req_valid = 2'b11;
      alu_ready = 1'b0;
      rsp_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("rst_req_ready", req_ready, 0);
      check("rst_alu_en", alu_en, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_tag", rsp_tag, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_err", rsp_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      busy = 1'b0;
      m_last = 1;
   endtask

   task automatic run(input int budget, input int mode, input int abort_at, input bit allow_budget);
      int         start;
      int         rel;
      int         w;
      int         eff;
      bit         exec;
      bit         resp;
      logic [1:0] v;
      logic [1:0] exp_rdy;
      start = cyc;
      forever begin
         rel = cyc - start;
         if (!busy && q0.size() == 0 && q1.size() == 0) return;
         if (rel >= budget) begin
            if (!allow_budget) check("run_budget_pending", q0.size() + q1.size() + int'(busy), 0);
            return;
         end
         v[0] = (q0.size() > 0) && (q0[0].avail <= rel);
         v[1] = (q1.size() > 0) && (q1[0].avail <= rel);
         req_valid = v;
         req_op[6:0]      = v[0] ? q0[0].op  : 7'($urandom);
         req_op[13:7]     = v[1] ? q1[0].op  : 7'($urandom);
         req_a[DW-1:0]    = v[0] ? q0[0].a   : $urandom;
         req_a[2*DW-1:DW] = v[1] ? q1[0].a   : $urandom;
         req_b[DW-1:0]    = v[0] ? q0[0].b   : $urandom;
         req_b[2*DW-1:DW] = v[1] ? q1[0].b   : $urandom;
         req_tag[TW-1:0]    = v[0] ? q0[0].tag : TW'($urandom);
         req_tag[2*TW-1:TW] = v[1] ? q1[0].tag : TW'($urandom);
         eff  = busy ? eff_lat(cur.lat) : 0;
         exec = busy && (cyc > acc) && (cyc <= acc + eff);
         resp = busy && (cyc > acc + eff);
         alu_ready  = busy && (cur.lat != 0) && (cyc == acc + cur.lat);
         alu_result = alu_ready ? cur.res : $urandom;
         case (mode)
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            2:       rsp_ready = !(resp && (cyc <= acc + eff + 10));
            default: rsp_ready = 1'b1;
         endcase
         if (rel == abort_at) begin
            apply_reset();
            return;
         end
         @(negedge clk);
         w = -1;
         exp_rdy = 2'b00;
         if (!busy && v != 2'b00) begin
            w = v[1 - m_last] ? 1 - m_last : m_last;
            exp_rdy = (w == 1) ? 2'b10 : 2'b01;
         end
         check("req_ready", req_ready, exp_rdy);
         check("alu_en", alu_en, exec);
         check("alu_op", alu_op, exec ? cur.op : 7'd0);
         check("alu_a", alu_a, exec ? cur.a : '0);
         check("alu_b", alu_b, exec ? cur.b : '0);
         check("rsp_valid", rsp_valid, resp);
         if (resp) begin
            check("rsp_id", rsp_id, cur.id);
            check("rsp_tag", rsp_tag, cur.tag);
            check("rsp_data", rsp_data, exp_err(cur.lat) ? '0 : cur.res);
            check("rsp_err", rsp_err, exp_err(cur.lat));
            if (rsp_ready) begin
               busy = 1'b0;
               n_done++;
            end
         end
         if (w >= 0) begin
            if (w == 0) cur = q0.pop_front();
            else cur = q1.pop_front();
            busy = 1'b1;
            acc = cyc;
            m_last = w;
            g_id.push_back(w);
            g_cyc.push_back(cyc);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: observed still running expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      int d;
      apply_reset();

      // Single ADD from R0, ALU answers in the first EXEC cycle.
      g_id.delete(); g_cyc.delete();
      add(0, 7'h18, 5, 7, 3, 1, 12, 0);
      run(50, 0, -1, 0);
      check("t1_ngrant", g_id.size(), 1);
      if (g_id.size() >= 1) check("t1_grant_id", g_id[0], 0);

      // Continuous contention: alternating grants every 3 cycles.
      apply_reset();
      g_id.delete(); g_cyc.delete();
      for (int i = 0; i < 2; i++) begin
         add(0, 7'h18, i, 1, 4'(i), 1, i + 1, 0);
         add(1, 7'h19, i, 2, 4'(8 + i), 1, i + 2, 0);
      end
      run(100, 0, -1, 0);
      check("t2_ngrant", g_id.size(), 4);
      if (g_id.size() == 4) begin
         for (int i = 0; i < 4; i++) check("t2_order", g_id[i], i % 2);
         for (int i = 1; i < 4; i++) check("t2_spacing", g_cyc[i] - g_cyc[i-1], 3);
      end

      // Long DIV from R1 while R0 waits.
      g_id.delete(); g_cyc.delete();
      add(1, 7'h31, 100, 7, 5, 34, 14, 0);
      add(0, 7'h18, 1, 2, 6, 1, 3, 3);
      run(200, 0, -1, 0);
      check("t3_ngrant", g_id.size(), 2);
      if (g_id.size() == 2) begin
         check("t3_first_id", g_id[0], 1);
         check("t3_r0_wait", g_cyc[1] - g_cyc[0], 36);
      end

      // Response backpressure for 10 cycles with R0 pending.
      g_id.delete(); g_cyc.delete();
      add(0, 7'h20, 9, 9, 1, 1, 81, 0);
      add(0, 7'h21, 3, 4, 2, 2, 7, 2);
      run(100, 2, -1, 0);
      check("t4_ngrant", g_id.size(), 2);
      if (g_id.size() == 2) check("t4_gap", g_cyc[1] - g_cyc[0], 13);

      // ALU ready in the same cycle the watchdog would expire.
      d = n_done;
      add(1, 7'h33, 50, 3, 9, TO, 32'hABCD, 0);
      run(200, 0, -1, 0);
      check("t5_done", n_done - d, 1);

      // ALU never answers.
      d = n_done;
      g_id.delete(); g_cyc.delete();
      add(0, 7'h30, 1, 0, 7, 0, 0, 0);
`ifdef ALU_ARB_TIMEOUT_EN
      run(200, 0, -1, 0);
      check("t6_done", n_done - d, 1);
`else
      run(200, 0, -1, 1);
      check("t6_no_rsp", n_done - d, 0);
      apply_reset();
`endif

      // Random traffic with random latencies and backpressure.
      d = n_done;
      for (int i = 0; i < 40; i++) begin
         add(i % 2, 7'($urandom_range(0, 127)), $urandom, $urandom, TW'($urandom),
             $urandom_range(1, 40), $urandom, $urandom_range(0, 300));
      end
      run(5000, 1, -1, 0);
      check("t7_done", n_done - d, 40);

      // Reset during EXEC of an R1 operation.
      d = n_done;
      add(1, 7'h31, 77, 5, 2, 30, 15, 0);
      run(1000, 0, 8, 0);
      check("t8_no_rsp", n_done - d, 0);
      g_id.delete(); g_cyc.delete();
      add(0, 7'h18, 2, 2, 1, 1, 4, 0);
      add(1, 7'h18, 3, 3, 2, 1, 6, 0);
      run(100, 0, -1, 0);
      check("t8_ngrant", g_id.size(), 2);
      if (g_id.size() == 2) begin
         check("t8_first_id", g_id[0], 0);
         check("t8_second_id", g_id[1], 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-requester arbiter and sequencer for the shared integer ALU/divider. It accepts ALU operation requests (7-bit `alu_opcode_e` operator plus two operands) from the issue path (requester 0) and a debug/test injection port (requester 1). It grants them round-robin and holds the ALU inputs stable until the ALU signals completion, including multicycle DIV/REM. It then returns a tagged response through a backpressured output register.

## Interface
Parameters:
- `DATA_W`, 32, operand/result width.
- `TAG_W`, 4, opaque request tag width, echoed in the response.
- `TIMEOUT`, 64, watchdog limit in EXEC cycles; range 2..1023.

Ports (requester n occupies packed slice n):
- Reset is asynchronous and active-high: `rst_i` asserts asynchronously and is released synchronously to `clk_i`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous active-high reset.
- `req_valid_i`  in  2  request valid per requester.
- `req_ready_o`  out  2  request accepted this cycle; one-hot or zero.
- `req_op_i`  in  2x7  ALU operator, packed `[7n+6:7n]`.
- `req_a_i`, `req_b_i`  in  2xDATA_W  operands.
- `req_tag_i`  in  2xTAG_W  request tag.
- `alu_en_o`  out  1  ALU operation active.
- `alu_operator_o`  out  7  operator driven to the ALU.
- `alu_operand_a_o`, `alu_operand_b_o`  out  DATA_W  operands driven to the ALU.
- `alu_ready_i`  in  1  ALU result valid this cycle.
- `alu_result_i`  in  DATA_W  ALU result.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted.
- `rsp_id_o`  out  1  index of the granted requester.
- `rsp_tag_o`  out  TAG_W  echoed tag.
- `rsp_data_o`  out  DATA_W  result.
- `rsp_err_o`  out  1  watchdog timeout flag.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid_i` bit is set, grant one requester and assert its `req_ready_o` combinationally in the same cycle.
  - Latch the granted requester's op, a, b, tag and index; go to EXEC.
  - Arbitration: requester `~last_grant` wins if valid, otherwise the other valid requester wins. `last_grant` updates on every grant.
- **EXEC**
  - Drive `alu_en_o`=1. Drive `alu_operator_o` and the operands from the latched registers; they stay stable for the whole EXEC period.
  - When `alu_ready_i`=1: capture `alu_result_i` into `rsp_data_o`, set `rsp_err_o`=0, go to RESP.
- **RESP**
  - Drive `rsp_valid_o`=1. Hold `rsp_*` stable until `rsp_ready_i`=1, then go to IDLE.
  - `req_ready_o` is 0 in this state, even in the handshake cycle.
- `req_ready_o` is 0 outside IDLE. Requests that are not granted must hold their valid signal; this block does not drop them.
- `alu_en_o`, `alu_operator_o` and the operands are all 0 outside EXEC.
- Opcode contents are not interpreted. DIV/REM (0x30–0x33) differ only in that `alu_ready_i` arrives later.

## Timing
- Reset values:
  - All outputs are 0.
  - `last_grant`=1, so requester 0 wins the first contention.
  - The watchdog counter is 0.
- Assertion of `rst_i` in any state returns the FSM to IDLE. The in-flight operation is discarded and no response is produced.
- Accept in cycle T gives EXEC from T+1.
- Single-cycle op with `alu_ready_i` at T+1: `rsp_valid_o` at T+2.
- ALU ready at cycle T+k: `rsp_valid_o` at T+k+1.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP), with `rsp_ready_i` held high.
- The watchdog counter clears on grant and increments in each EXEC cycle without `alu_ready_i`.
- If `alu_ready_i` and the watchdog limit coincide in the same cycle, `alu_ready_i` wins: valid data, `rsp_err_o`=0.

## Configuration
- The macro is `ALU_ARB_TIMEOUT_EN`.
- **Defined:** after `TIMEOUT` consecutive EXEC cycles without `alu_ready_i`, go to RESP with `rsp_err_o`=1 and `rsp_data_o`=0. A response on this path is produced `TIMEOUT`+1 cycles after the accept.
- **Undefined:** the counter is not built, `rsp_err_o` is tied to 0, and EXEC waits indefinitely for `alu_ready_i`.

## Test plan
- R0 issues `ALU_ADD` (0x18) with a=5, b=7, tag=3; ALU returns 12 with ready in the first EXEC cycle. Required: `rsp_valid_o` 2 cycles after accept, with id=0, tag=3, data=12, err=0.
- R0 and R1 hold valid continuously for 4 operations with `rsp_ready_i`=1. Required: grants in order 0,1,0,1 at 3-cycle spacing.
- R1 issues `ALU_DIV` (0x31) with a=100, b=7; ALU raises ready 34 cycles into EXEC with result 14. Required: operands and `alu_en_o` stable for all 34 cycles, `req_ready_o`=0 throughout, then response data=14, id=1.
- `rsp_ready_i` held low for 10 cycles in RESP while R0 is valid. Required: `rsp_*` stable, no grant, and R0 is granted in the cycle after the handshake.
- With `ALU_ARB_TIMEOUT_EN` defined and `TIMEOUT`=64, `alu_ready_i` is never raised. Required: response at accept+65 with err=1, data=0. Without the macro, no response after 200 cycles.
- `rst_i` pulsed during EXEC of an R1 operation. Required: all outputs 0 immediately and no response; afterwards, with both requesters valid, the first grant goes to R0.
